uart_tx8: RTL and testbench

Eight-bit UART transmitter: 8N1 (optionally 8N2), LSB first, idle-high line. Accepts one byte per handshake and serializes it onto `txOut` at BAUD_RATE, derived from the system clock by an integer bit-period divider. It is the transmit side paired with the `Uart8` receive path, and must be able to drive `Uart8.rxIn` directly at the same CLOCK_RATE.

---
 rtl/uart_tx8_if.sv | 28 ++
 rtl/uart_tx8.sv | 124 ++++++++++++
 tb/tb_uart_tx8.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx8_if.sv
// Byte-transmit handshake bundle for uart_tx8: request/data in, line and status out.
// txStart is the request; the transmitter takes it on a rising edge where it is idle and txEn=1.
interface uart_tx8_if;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txBusy;
  logic       txDone;
  logic       txOut;

  modport master (
    output txEn,
    output txStart,
    output txIn,
    input  txBusy,
    input  txDone,
    input  txOut
  );

  modport slave (
    input  txEn,
    input  txStart,
    input  txIn,
    output txBusy,
    output txDone,
    output txOut
  );
endinterface

// File: rtl/uart_tx8.sv
// Eight-bit UART transmitter, 8N1/8N2, LSB first, idle-high line.
// Bit period is an integer divider of the system clock; all outputs are registered.
module uart_tx8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx8_if.slave  tx,
  output logic [1:0] dbg_state
);

  localparam int D     = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W = (D >= 2) ? $clog2(D) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(D - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (D < 2) begin : g_bad_divider
    $error("uart_tx8: CLOCK_RATE / BAUD_RATE must be at least 2");
  end

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx8: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             line;
  logic             busy;
  logic             done;

  // bit_idx counts data bits in DATA and stop periods in STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      line    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          line <= 1'b1;
          if (tx.txEn && tx.txStart) begin
            shift   <= tx.txIn;
            state   <= START;
            line    <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end

        START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= DATA;
            line  <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              line    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              line    <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          line  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.txOut   = line;
  assign tx.txBusy  = busy;
  assign tx.txDone  = done;
  assign dbg_state  = state;

endmodule

// File: tb/tb_uart_tx8.sv
// Bench for uart_tx8: a one-stop-bit and a two-stop-bit instance at a small divider.
// A line decoder on the first instance checks every frame against the expected-byte queue.
module tb_uart_tx8;

  localparam int CR = 1000;
  localparam int BR = 96;
  localparam int D  = CR / BR;   // 10, truncated from 10.41
  localparam int F1 = 10 * D;
  localparam int F2 = 11 * D;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  uart_tx8_if ifa ();
  uart_tx8_if ifb ();
  logic [1:0] st_a;
  logic [1:0] st_b;

  uart_tx8 #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(rst1), .tx(ifa), .dbg_state(st_a)
  );
  uart_tx8 #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(rst2), .tx(ifb), .dbg_state(st_b)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic mon_en = 1'b0;
  int frames_seen = 0;

  initial begin
    ifa.txEn = 1'b0; ifa.txStart = 1'b0; ifa.txIn = 8'h00;
    ifb.txEn = 1'b0; ifb.txStart = 1'b0; ifb.txIn = 8'h00;
  end

  // Line decoder for dut_a: samples mid-bit on falling clock edges.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !ifa.txOut) begin
        repeat (D / 2) @(negedge clk);
        total++;
        if (ifa.txOut !== 1'b0) begin
          bad++; $display("FAIL mon_start got=%b exp=0", ifa.txOut);
        end
        for (int k = 0; k < 8; k++) begin
          repeat (D) @(negedge clk);
          got[k] = ifa.txOut;
        end
        repeat (D) @(negedge clk);
        total++;
        if (ifa.txOut !== 1'b1) begin
          bad++; $display("FAIL mon_stop got=%b exp=1", ifa.txOut);
        end
        frames_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL mon_extra_frame got=%h exp=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            bad++; $display("FAIL mon_byte got=%h exp=%h", got, exp);
          end
        end
      end
      prev = ifa.txOut;
    end
  end

  // Driver: one-cycle request; returns on the falling edge just after the accepting edge.
  task automatic start_a(input logic [7:0] b);
    @(negedge clk);
    ifa.txEn = 1'b1; ifa.txIn = b; ifa.txStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.txStart = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] b);
    @(negedge clk);
    ifb.txEn = 1'b1; ifb.txIn = b; ifb.txStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifb.txStart = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * F1 && !ok; i++) begin
      @(negedge clk);
      if (ifa.txDone) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL %s_done_timeout got=0 exp=1", tag);
    end
  endtask

  task automatic test_reset();
    int lows;
    rst1 = 1'b1; rst2 = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if ({ifa.txOut, ifa.txBusy, ifa.txDone} !== 3'b100) begin
      bad++; $display("FAIL reset_a got=%b exp=100", {ifa.txOut, ifa.txBusy, ifa.txDone});
    end
    total++;
    if ({ifb.txOut, ifb.txBusy, ifb.txDone} !== 3'b100) begin
      bad++; $display("FAIL reset_b got=%b exp=100", {ifb.txOut, ifb.txBusy, ifb.txDone});
    end
    total++;
    if (st_a !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", st_a);
    end
    rst1 = 1'b0; rst2 = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.txOut !== 1'b1 || ifb.txOut !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL reset_release_glitch got=%0d exp=0", lows);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] line_exp;
    logic [9:0] line_got;
    int busy_n, done_n, done_at;
    line_exp = {1'b1, 8'h35, 1'b0};
    line_got = '0;
    exp_q.push_back(8'h35);
    start_a(8'h35);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int m = 0; m < F1 + 5; m++) begin
      if (m > 0) @(negedge clk);
      if (ifa.txBusy) busy_n++;
      if (ifa.txDone) begin
        done_n++;
        if (done_at < 0) done_at = m;
      end
      if ((m % D) == D / 2 && (m / D) < 10) line_got[m / D] = ifa.txOut;
    end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (line_got[k] !== line_exp[k]) begin
        bad++; $display("FAIL single_bit%0d got=%b exp=%b", k, line_got[k], line_exp[k]);
      end
    end
    total++;
    if (busy_n != F1) begin
      bad++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_n, F1);
    end
    total++;
    if (done_n != 1 || done_at != F1) begin
      bad++; $display("FAIL single_done got=%0d@%0d exp=1@%0d", done_n, done_at, F1);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    int f0;
    bytes[0] = 8'h35; bytes[1] = 8'h00; bytes[2] = 8'hFF;
    f0 = frames_seen;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      start_a(bytes[i]);
      wait_done_a("loopback");
    end
    repeat (3) @(negedge clk);
    total++;
    if (frames_seen - f0 != 3) begin
      bad++; $display("FAIL loopback_frames got=%0d exp=3", frames_seen - f0);
    end
  endtask

  task automatic test_back_to_back();
    int rise [3];
    int nr, f0, busy_after;
    logic pb;
    f0 = frames_seen; nr = 0; pb = 1'b0;
    rise[0] = 0; rise[1] = 0; rise[2] = 0;
    @(negedge clk);
    ifa.txEn = 1'b1; ifa.txIn = 8'hA5; ifa.txStart = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    for (int m = 0; m < 4 * F1 && nr < 3; m++) begin
      @(negedge clk);
      if (ifa.txBusy && !pb) begin
        rise[nr] = m;
        nr++;
      end
      if (nr == 1 && m == rise[0] + 4 * D) ifa.txIn = 8'h5A;
      if (nr == 3) ifa.txStart = 1'b0;
      pb = ifa.txBusy;
    end
    ifa.txStart = 1'b0;
    total++;
    if (nr != 3) begin
      bad++; $display("FAIL b2b_accepts got=%0d exp=3", nr);
    end
    total++;
    if (rise[1] - rise[0] != F1 + 1) begin
      bad++; $display("FAIL b2b_gap1 got=%0d exp=%0d", rise[1] - rise[0], F1 + 1);
    end
    total++;
    if (rise[2] - rise[1] != F1 + 1) begin
      bad++; $display("FAIL b2b_gap2 got=%0d exp=%0d", rise[2] - rise[1], F1 + 1);
    end
    wait_done_a("b2b");

    exp_q.push_back(8'h3C);
    start_a(8'h3C);
    repeat (3 * D) @(negedge clk);
    ifa.txIn = 8'hEE; ifa.txStart = 1'b1;
    @(negedge clk);
    ifa.txStart = 1'b0;
    wait_done_a("ignore");
    busy_after = 0;
    repeat (2 * F1) begin
      @(negedge clk);
      if (ifa.txBusy) busy_after++;
    end
    total++;
    if (busy_after != 0) begin
      bad++; $display("FAIL ignore_busy_after got=%0d exp=0", busy_after);
    end
    total++;
    if (frames_seen - f0 != 4) begin
      bad++; $display("FAIL b2b_frames got=%0d exp=4", frames_seen - f0);
    end
  endtask

  task automatic test_enable_gating();
    int lows, busy_n, f0;
    @(negedge clk);
    ifa.txEn = 1'b0; ifa.txStart = 1'b1; ifa.txIn = 8'h77;
    lows = 0; busy_n = 0;
    repeat (20000) begin
      @(negedge clk);
      if (ifa.txOut !== 1'b1) lows++;
      if (ifa.txBusy !== 1'b0) busy_n++;
    end
    total++;
    if (lows != 0 || busy_n != 0) begin
      bad++; $display("FAIL gate_disabled got=lows%0d/busy%0d exp=0/0", lows, busy_n);
    end
    f0 = frames_seen;
    exp_q.push_back(8'h96);
    ifa.txIn = 8'h96; ifa.txEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (5 * D + D / 2) @(negedge clk);
    ifa.txEn = 1'b0;
    total++;
    if (ifa.txBusy !== 1'b1) begin
      bad++; $display("FAIL gate_mid_busy got=%b exp=1", ifa.txBusy);
    end
    wait_done_a("gate");
    busy_n = 0;
    repeat (3 * F1) begin
      @(negedge clk);
      if (ifa.txBusy) busy_n++;
    end
    ifa.txStart = 1'b0;
    total++;
    if (busy_n != 0 || frames_seen - f0 != 1) begin
      bad++; $display("FAIL gate_after_drop got=busy%0d/frames%0d exp=0/1", busy_n, frames_seen - f0);
    end
  endtask

  task automatic test_stop2_frame(input logic [7:0] b);
    logic [10:0] line_exp;
    logic [10:0] line_got;
    int done_n, done_at;
    line_exp = {2'b11, b, 1'b0};
    line_got = '0;
    start_b(b);
    done_n = 0; done_at = -1;
    for (int m = 0; m < F2 + 5; m++) begin
      if (m > 0) @(negedge clk);
      if (ifb.txDone) begin
        done_n++;
        if (done_at < 0) done_at = m;
      end
      if ((m % D) == D / 2 && (m / D) < 11) line_got[m / D] = ifb.txOut;
    end
    total++;
    if (line_got !== line_exp) begin
      bad++; $display("FAIL stop2_line_%h got=%b exp=%b", b, line_got, line_exp);
    end
    total++;
    if (done_n != 1 || done_at != F2) begin
      bad++; $display("FAIL stop2_done_%h got=%0d@%0d exp=1@%0d", b, done_n, done_at, F2);
    end
  endtask

  task automatic test_mid_frame_reset();
    int lows;
    start_b(8'h00);
    repeat (4 * D + D / 2) @(negedge clk);
    total++;
    if (ifb.txOut !== 1'b0 || ifb.txBusy !== 1'b1) begin
      bad++; $display("FAIL midreset_pre got=%b%b exp=01", ifb.txOut, ifb.txBusy);
    end
    rst2 = 1'b1;
    #1;
    total++;
    if ({ifb.txOut, ifb.txBusy, ifb.txDone} !== 3'b100) begin
      bad++; $display("FAIL midreset_async got=%b exp=100", {ifb.txOut, ifb.txBusy, ifb.txDone});
    end
    repeat (100) @(negedge clk);
    rst2 = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifb.txOut !== 1'b1 || ifb.txBusy !== 1'b0) lows++;
    end
    total++;
    if (lows != 0 || st_b !== 2'd0) begin
      bad++; $display("FAIL midreset_release got=%0d/st%0d exp=0/st0", lows, st_b);
    end
    test_stop2_frame(8'hC3);
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_single_frame();
    test_loopback();
    test_back_to_back();
    test_enable_gating();
    test_stop2_frame(8'h35);
    test_mid_frame_reset();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
